// File: rtl/pim_matrix_mem.sv
// Matrix memory with a built-in fetch/writeback sequencer feeding the PIM controller.
// Streams A/B element pairs out over valid/ready and writes the returned results back.
module pim_matrix_mem #(
    parameter int unsigned LEN             = 32,
    parameter int unsigned MEM_ELEMENTS    = 1024,
    parameter int unsigned MAX_MATRIX_SIZE = 16,
    parameter int unsigned ADDR_W          = $clog2(MEM_ELEMENTS),
    parameter int unsigned SIZE_W          = $clog2(MAX_MATRIX_SIZE) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [LEN-1:0]    host_wdata,
    output logic [LEN-1:0]    host_rdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [SIZE_W-1:0] matrix_size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [LEN-1:0]    op_a,
    output logic [LEN-1:0]    op_b,
    output logic              op_last,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [LEN-1:0]    res_data
);

    localparam int unsigned CNT_W = 2 * SIZE_W;
    // One spare bit so base + E never wraps during the bounds check.
    localparam int unsigned CHK_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q;
    logic [LEN-1:0]    mem [MEM_ELEMENTS];
    logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
    logic [CNT_W-1:0]  elems_q, fetch_cnt_q, wb_cnt_q;

    logic [CNT_W-1:0]  elems_in;
    logic              cfg_err;
    logic              fetch_go, pair_xfer, last_xfer, res_fire, wb_all, finish;
    logic [ADDR_W-1:0] rd_a_addr, rd_b_addr, wr_addr;
    logic              wr_en;
    logic [LEN-1:0]    wr_data;

    function automatic logic region_over(input logic [ADDR_W-1:0] base,
                                         input logic [CNT_W-1:0]  n);
        return (CHK_W'(base) + CHK_W'(n)) > CHK_W'(MEM_ELEMENTS);
    endfunction

    always_comb begin
        elems_in  = CNT_W'(matrix_size) * CNT_W'(matrix_size);
        cfg_err   = (matrix_size == '0) || (matrix_size > SIZE_W'(MAX_MATRIX_SIZE)) ||
                    region_over(src1_addr, elems_in) || region_over(src2_addr, elems_in) ||
                    region_over(dst_addr, elems_in);
        fetch_go  = (!op_valid || op_ready) && (fetch_cnt_q < elems_q);
        pair_xfer = op_valid && op_ready;
        last_xfer = pair_xfer && op_last;
        res_fire  = res_valid && res_ready;
        wb_all    = (wb_cnt_q == elems_q) || (res_fire && (wb_cnt_q == elems_q - CNT_W'(1)));
        finish    = ((state_q == StRun) && last_xfer && wb_all) ||
                    ((state_q == StDrain) && wb_all);
        rd_a_addr = src1_q + ADDR_W'(fetch_cnt_q);
        rd_b_addr = src2_q + ADDR_W'(fetch_cnt_q);
        // Result writes only happen while busy, so they never collide with host writes.
        wr_en     = rst && ((host_we && !busy) || res_fire);
        wr_addr   = res_fire ? (dst_q + ADDR_W'(wb_cnt_q)) : host_addr;
        wr_data   = res_fire ? res_data : host_wdata;
    end

    assign res_ready = (state_q != StIdle) && (wb_cnt_q < elems_q);

    // Memory array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            op_valid    <= 1'b0;
            op_last     <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            host_rdata  <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dst_q       <= '0;
            elems_q     <= '0;
            fetch_cnt_q <= '0;
            wb_cnt_q    <= '0;
        end else begin
            done       <= 1'b0;
            host_rdata <= mem[host_addr];
            if (res_fire) begin
                wb_cnt_q <= wb_cnt_q + CNT_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_err) begin
                            err <= 1'b1;
                        end else begin
                            err         <= 1'b0;
                            src1_q      <= src1_addr;
                            src2_q      <= src2_addr;
                            dst_q       <= dst_addr;
                            elems_q     <= elems_in;
                            fetch_cnt_q <= '0;
                            wb_cnt_q    <= '0;
                            busy        <= 1'b1;
                            state_q     <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (fetch_go) begin
                        op_a        <= mem[rd_a_addr];
                        op_b        <= mem[rd_b_addr];
                        op_valid    <= 1'b1;
                        op_last     <= (fetch_cnt_q == elems_q - CNT_W'(1));
                        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
                    end else if (pair_xfer) begin
                        op_valid <= 1'b0;
                        op_last  <= 1'b0;
                    end
                    if (finish) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (last_xfer) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (finish) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_matrix_mem.sv
// Self-checking bench for pim_matrix_mem: vector table of operations plus reset/host sequences,
// checked against an array model of the memory and the expected pair/result streams.
module tb_pim_matrix_mem;

    logic        clk;
    logic        rst;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        start;
    logic [9:0]  src1_addr, src2_addr, dst_addr;
    logic [4:0]  matrix_size;
    logic        busy, done, err;
    logic        op_valid, op_ready, op_last;
    logic [31:0] op_a, op_b;
    logic        res_valid, res_ready;
    logic [31:0] res_data;

    pim_matrix_mem #(
        .LEN            (32),
        .MEM_ELEMENTS   (1024),
        .MAX_MATRIX_SIZE(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .start      (start),
        .src1_addr  (src1_addr),
        .src2_addr  (src2_addr),
        .dst_addr   (dst_addr),
        .matrix_size(matrix_size),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_last    (op_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_m [1024];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int n;
        int s1;
        int s2;
        int d;
        int mode;   // 0: op_ready held high, 1: ready pattern 1,0,0, 2: random ready
        bit tamper; // try a host write while busy
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit cfg_bad(input int n, input int s1, input int s2, input int d);
        int e;
        e = n * n;
        return (n == 0) || (n > 16) || (s1 + e > 1024) || (s2 + e > 1024) || (d + e > 1024);
    endfunction

    task automatic host_write(input int a, input logic [31:0] v);
        @(negedge clk);
        host_we    = 1'b1;
        host_addr  = a[9:0];
        host_wdata = v;
        @(negedge clk);
        host_we    = 1'b0;
        mem_m[a]   = v;
    endtask

    task automatic host_read(input int a, output logic [31:0] v);
        @(negedge clk);
        host_addr = a[9:0];
        @(posedge clk);
        #1 v = host_rdata;
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        logic [31:0] ea [256];
        logic [31:0] eb [256];
        logic [31:0] er [256];
        logic [31:0] rv, ha, hb;
        logic        hl;
        int          e, kp, kr, cyc, first, lastc;
        bit          bad, stalled, seen_done, extra, seen_valid;

        e   = t.n * t.n;
        bad = cfg_bad(t.n, t.s1, t.s2, t.d);
        if (!bad) begin
            for (int k = 0; k < e; k++) begin
                host_write(t.s1 + k, (idx == 0) ? 32'(k + 1) : $urandom);
                host_write(t.s2 + k, (idx == 0) ? 32'(k + 5) : $urandom);
                er[k] = (idx == 0) ? 32'((k + 1) * 10) : $urandom;
            end
            for (int k = 0; k < e; k++) begin
                ea[k] = mem_m[t.s1 + k];
                eb[k] = mem_m[t.s2 + k];
            end
        end

        @(negedge clk);
        matrix_size = t.n[4:0];
        src1_addr   = t.s1[9:0];
        src2_addr   = t.s2[9:0];
        dst_addr    = t.d[9:0];
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        if (bad) begin
            chk($sformatf("v%0d_err_set", idx), err, 1);
            chk($sformatf("v%0d_err_busy", idx), busy, 0);
            seen_valid = 0;
            repeat (4) begin
                @(negedge clk);
                if (op_valid || busy) seen_valid = 1;
            end
            chk($sformatf("v%0d_err_no_activity", idx), seen_valid, 0);
            return;
        end

        chk($sformatf("v%0d_start_busy", idx), busy, 1);
        chk($sformatf("v%0d_start_err_clear", idx), err, 0);
        chk($sformatf("v%0d_start_no_valid", idx), op_valid, 0);
        // Config inputs are scrambled after start; the run must use the latched values.
        matrix_size = 5'd0;
        src1_addr   = 10'd1000;
        src2_addr   = 10'd1001;
        dst_addr    = 10'd1002;

        kp = 0; kr = 0; cyc = 0; first = -1; lastc = -1;
        stalled = 0; seen_done = 0; extra = 0;
        ha = '0; hb = '0; hl = 1'b0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            host_we = 1'b0;
            if (seen_done) begin
                chk($sformatf("v%0d_done_single_pulse", idx), done, 0);
                break;
            end
            if (done) begin
                seen_done = 1;
                op_ready  = 1'b0;
                res_valid = 1'b0;
                chk($sformatf("v%0d_pairs_at_done", idx), kp, e);
                chk($sformatf("v%0d_results_at_done", idx), kr, e);
                chk($sformatf("v%0d_busy_at_done", idx), busy, 0);
                chk($sformatf("v%0d_res_ready_at_done", idx), res_ready, 0);
                continue;
            end
            if (t.tamper && cyc == 2) begin
                host_we    = 1'b1;
                host_addr  = 10'd900;
                host_wdata = 32'hBAD0BAD0;
            end
            if (stalled) chk($sformatf("v%0d_stall_hold", idx), {op_a, op_b, op_last}, {ha, hb, hl});
            if (op_valid && first < 0) first = cyc;
            case (t.mode)
                0:       op_ready = 1'b1;
                1:       op_ready = (cyc % 3 == 0);
                default: op_ready = 1'($urandom_range(0, 1));
            endcase
            if (op_valid && op_ready) begin
                if (kp < e) chk($sformatf("v%0d_pair%0d", idx, kp), {op_a, op_b, op_last},
                                {ea[kp], eb[kp], 1'(kp == e - 1)});
                else chk($sformatf("v%0d_extra_pair", idx), kp, e - 1);
                kp++;
                lastc   = cyc;
                stalled = 0;
            end else begin
                stalled = op_valid;
                ha = op_a; hb = op_b; hl = op_last;
            end
            if (kr >= e && res_ready) extra = 1;
            res_valid = (kr < e) && ((t.mode == 0) ? ($urandom_range(0, 3) != 0)
                                                   : ($urandom_range(0, 1) == 1));
            res_data  = res_valid ? er[kr] : $urandom;
            if (res_valid && res_ready) kr++;
        end
        op_ready  = 1'b0;
        res_valid = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), seen_done, 1);
        chk($sformatf("v%0d_first_valid_cycle", idx), first, 2);
        chk($sformatf("v%0d_no_ready_past_E", idx), extra, 0);
        if (t.mode == 0) chk($sformatf("v%0d_back_to_back", idx), lastc - first, e - 1);

        for (int k = 0; k < e; k++) mem_m[t.d + k] = er[k];
        for (int k = 0; k < e; k++) begin
            host_read(t.d + k, rv);
            chk($sformatf("v%0d_wb%0d", idx, k), rv, mem_m[t.d + k]);
        end
        if (t.tamper) begin
            host_read(900, rv);
            chk($sformatf("v%0d_busy_host_we_ignored", idx), rv, mem_m[900]);
        end
    endtask

    initial begin
        logic [31:0] rv;
        int          kp, cyc;

        vecs[0] = '{n: 2,  s1: 0,    s2: 16,   d: 32,   mode: 0, tamper: 1};
        vecs[1] = '{n: 2,  s1: 0,    s2: 16,   d: 36,   mode: 1, tamper: 0};
        vecs[2] = '{n: 0,  s1: 0,    s2: 16,   d: 32,   mode: 0, tamper: 0};
        vecs[3] = '{n: 17, s1: 0,    s2: 16,   d: 32,   mode: 0, tamper: 0};
        vecs[4] = '{n: 4,  s1: 1020, s2: 16,   d: 32,   mode: 0, tamper: 0};
        vecs[5] = '{n: 4,  s1: 100,  s2: 200,  d: 300,  mode: 2, tamper: 1};
        vecs[6] = '{n: 3,  s1: 400,  s2: 500,  d: 1015, mode: 2, tamper: 0};
        vecs[7] = '{n: 4,  s1: 600,  s2: 1009, d: 700,  mode: 0, tamper: 0};
        vecs[8] = '{n: 16, s1: 0,    s2: 256,  d: 512,  mode: 2, tamper: 0};
        vecs[9] = '{n: 1,  s1: 50,   s2: 60,   d: 70,   mode: 0, tamper: 0};

        rst = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; start = 1'b0;
        src1_addr = '0; src2_addr = '0; dst_addr = '0; matrix_size = '0;
        op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, err, op_valid, op_last, res_ready, op_a, op_b, host_rdata},
            '0);
        @(negedge clk);
        rst = 1'b1;

        host_write(5, 32'hDEAD);
        host_read(5, rv);
        chk("host_readback", rv, 32'hDEAD);
        host_write(900, 32'h11112222);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Abort a run after two pairs, then confirm a fresh run behaves and memory survived.
        host_write(60, 32'h5A5A5A5A);
        @(negedge clk);
        matrix_size = 5'd2; src1_addr = 10'd0; src2_addr = 10'd16; dst_addr = 10'd60;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        kp = 0; cyc = 0;
        while (kp < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            op_ready = 1'b1;
            if (op_valid) kp++;
        end
        chk("abort_two_pairs_seen", kp, 2);
        @(negedge clk);
        rst = 1'b0;
        op_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset_outputs",
            {busy, done, err, op_valid, op_last, res_ready, op_a, op_b, host_rdata}, '0);
        @(negedge clk);
        rst = 1'b1;
        host_read(60, rv);
        chk("abort_dst_untouched", rv, 32'h5A5A5A5A);
        run_vec(10, '{n: 1, s1: 0, s2: 16, d: 60, mode: 0, tamper: 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pim_matrix_mem.md
Name: pim_matrix_mem

Overview:
Parametrised matrix memory with a built-in fetch/writeback sequencer for the PIM controller.
- Host preloads and reads back words through a simple port.
- On start, streams paired A/B elements (row-major, contiguous from src1_addr/src2_addr) to the PIM controller over valid/ready.
- Concurrently accepts the result stream and writes it contiguously from dst_addr, then pulses done.
- Adds backpressure, error checking and a host port.

Parameters:
- LEN, 32, data width per element.
- MEM_ELEMENTS, 1024, number of memory words.
- MAX_MATRIX_SIZE, 16, largest supported N (NxN).
- ADDR_W, $clog2(MEM_ELEMENTS), address width.
- SIZE_W, $clog2(MAX_MATRIX_SIZE)+1, matrix_size width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- host_we  in  1  host write strobe.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  LEN  host write data.
- host_rdata  out  LEN  registered read of host_addr.
- start  in  1  launch request, sampled in IDLE.
- src1_addr  in  ADDR_W  base of matrix A.
- src2_addr  in  ADDR_W  base of matrix B.
- dst_addr  in  ADDR_W  base of result.
- matrix_size  in  SIZE_W  N.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky config error.
- op_valid  out  1  A/B pair valid.
- op_ready  in  1  PIM controller accepts pair.
- op_a  out  LEN  element A[k].
- op_b  out  LEN  element B[k].
- op_last  out  1  high with pair k = E-1.
- res_valid  in  1  result element valid.
- res_ready  out  1  block accepts result.
- res_data  in  LEN  result element.

Behaviour:
- Reset (rst=0 at a clk edge):
  - busy, done, err, op_valid, op_last, res_ready = 0; op_a, op_b, host_rdata = 0.
  - All counters cleared, state returns to IDLE.
  - Memory contents unchanged. This also applies to reset mid-operation: any in-flight pair is dropped.
- Memory array: 2 read ports (fetch A, B), 1 write port, plus host read. Read-old on same-cycle same-address read/write; a write is visible to reads from the next cycle.
- Host port:
  - host_rdata <= mem[host_addr] every cycle (1-cycle latency).
  - host_we honoured only when busy=0, ignored while busy.
- E = N*N, computed in 2*SIZE_W bits.
- States: IDLE, RUN, DRAIN.
- IDLE, start=1:
  - Error if N=0, N>MAX_MATRIX_SIZE, or base+E > MEM_ELEMENTS for any of the three regions. On error: err=1 next cycle, stay IDLE, busy stays 0.
  - Otherwise: err cleared, bases and E latched, fetch_cnt=wb_cnt=0, busy=1 next cycle, enter RUN.
  - Later changes to the address/size inputs have no effect until the next start.
- start while busy is ignored.
- RUN, fetch side:
  - The output register loads mem[srcA+fetch_cnt] and mem[srcB+fetch_cnt] when (op_valid=0 or op_ready=1) and fetch_cnt<E; fetch_cnt then increments.
  - First op_valid appears 2 cycles after the start edge (busy is already high).
  - Throughput is 1 pair/cycle with op_ready held high.
  - While op_valid=1 and op_ready=0, op_a/op_b/op_last hold stable.
  - A pair transfers on op_valid & op_ready. op_valid drops after pair E-1 transfers.
- Writeback side, active in RUN and DRAIN:
  - res_ready = 1 while wb_cnt<E.
  - On res_valid & res_ready: mem[dst+wb_cnt] <= res_data; wb_cnt increments.
  - Results may arrive before fetch completes.
- RUN -> DRAIN when the last pair transfers and wb_cnt<E.
- Completion (from RUN or DRAIN): when result E-1 is written and all pairs are transferred, then next cycle done=1, busy=0, res_ready=0, return to IDLE.
- Results beyond E are not accepted (res_ready=0).
- Overlapping dst and src regions are permitted and follow read-old/write-next-cycle ordering. No other ordering is guaranteed.

Test Plan:
- Host preload/readback: write mem[5]=0xDEAD -> host_rdata=0xDEAD one cycle after host_addr=5. host_we during busy -> word unchanged.
- N=2, src1=0 (1,2,3,4), src2=16 (5,6,7,8), op_ready=1 -> pairs (1,5),(2,6),(3,7),(4,8) on consecutive cycles starting 2 cycles after start; op_last with (4,8) only.
- Backpressure: op_ready toggles 1,0,0,1... -> each pair held stable while stalled; no pair dropped or duplicated; 4 transfers total.
- Writeback: dst=32, results 10,20,30,40 with res_valid gaps, including results arriving during fetch -> mem[32..35]=10,20,30,40; done single pulse; busy falls with done; res_ready=0 after the 4th result.
- Errors: N=0, N=17, and src1=1020 with N=4 -> err=1, busy stays 0, no op_valid. Next valid start clears err.
- Reset mid-RUN after 2 pairs -> all outputs at reset values next cycle. New start with N=1 runs cleanly. mem[dst] written only by the new run.
